uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among NUM_REQ byte-producing clients.
- Each client presents a level request plus a byte.
- The arbiter grants one client, issues a single-cycle tx_start with the byte, and waits for the transmitter's tx_done_tick.
- It then either continues that client's burst or re-arbitrates.
- It sits between client logic (command/response engines) and the shared UART transmitter, alongside the existing receiver path.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
DATA_BITS, 8, byte width per transfer
MAX_BURST, 4, maximum bytes sent per grant before mandatory re-arbitration (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-client level request; held high while the client has a byte ready
req_data  in  NUM_REQ*DATA_BITS  client bytes; client i owns slice [i*DATA_BITS +: DATA_BITS]
req_ack  out  NUM_REQ  one-cycle pulse to the client whose byte was just launched
grant  out  NUM_REQ  one-hot owner of the transmitter; all-zero when idle
tx_start  out  1  one-cycle launch pulse to the transmitter
tx_data  out  DATA_BITS  registered byte to the transmitter; valid while tx_start is high and held after
tx_done_tick  in  1  transmitter single-cycle pulse at end of the stop bit
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - state=IDLE; grant=0; req_ack=0; tx_start=0; tx_data=0; busy=0.
  - burst_cnt=0; rr_ptr=NUM_REQ-1, so client 0 has top priority after reset.
- States: IDLE, START, WAIT. Encoding is 2 bits; the unused code returns to IDLE.
- IDLE:
  - If req != 0, select the first asserted req scanning upward from rr_ptr+1 (mod NUM_REQ).
  - On that edge: grant <= onehot(sel); tx_data <= req_data[sel]; burst_cnt <= 0; state <= START.
  - If req == 0, stay in IDLE.
- START (exactly one cycle):
  - tx_start=1 and req_ack[sel]=1. Both are combinational from state and grant, so they are high only in this cycle.
  - On the edge: burst_cnt <= burst_cnt+1; state <= WAIT.
- WAIT:
  - Hold grant and tx_data until tx_done_tick.
  - On tx_done_tick, if req[sel]=1 and burst_cnt < MAX_BURST: tx_data <= req_data[sel]; state <= START. The burst continues back-to-back.
  - Otherwise: rr_ptr <= sel; grant <= 0; state <= IDLE.
- Latency:
  - A req rising in IDLE at cycle 0 produces grant and tx_start at cycle 1.
  - tx_done_tick at cycle k with the burst continuing produces tx_start at cycle k+1.
  - Re-arbitration costs one IDLE cycle, so the next tx_start is at cycle k+2.
- Client contract:
  - The byte is captured on the edge entering START.
  - After req_ack the client may change req_data or drop req. The new byte must be stable before the next tx_done_tick.
- Boundary conditions:
  - req[sel] dropping during START or WAIT: the captured byte is still sent and acked; the burst ends at tx_done_tick.
  - Simultaneous requests: strict rotation. A client that just used its grant has lowest priority next round.
  - Burst limit: when burst_cnt reaches MAX_BURST, the grant is released even if req is still high.
  - A lone requester is re-granted after a single IDLE cycle.
  - tx_done_tick in IDLE or START is ignored; no state change and no counter change.
  - req bits for non-granted clients are ignored during START and WAIT.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). No ack is issued for the in-flight byte. The transmitter shares the same reset.
- Widths:
  - burst_cnt is 4 bits.
  - rr_ptr is clog2(NUM_REQ) bits and wraps modulo NUM_REQ.

Decomposition:
- Shared package uart_pkg holds:
  - the DATA_BITS default;
  - the state localparams IDLE/START/WAIT;
  - a clog2 function.
- Sub-module rr_arbiter is purely combinational.
  - Inputs: req and rr_ptr.
  - Outputs: one-hot gnt and binary index sel.
  - It is reused by future TX/RX shared-resource blocks.

Test Plan:
- Single client: req=4'b0001, req_data[7:0]=8'hA5. Required: grant=0001 and tx_start=1 with tx_data=A5 at cycle 1; req_ack[0] pulses 1 cycle. Then drop req and pulse tx_done_tick; grant=0 and busy=0 next cycle.
- Contention: req=4'b0110 with bytes 11/22/33/44 from reset, all held high, each tx_done_tick pulsed 10 cycles after tx_start. Required launch order with MAX_BURST=1: 22, 33, 22, 33.
- Burst limit: MAX_BURST=4; client 0 holds req for 6 bytes 01..06; client 2 requests byte 0x77 from the start. Required sequence: 01, 02, 03, 04, 77, 05, 06.
- Drop during WAIT: client 3 is granted with 0x5A, and req[3] drops before tx_done_tick. Required: 5A sent once, req_ack[3] pulsed once, return to IDLE, no second tx_start.
- Stray tick and reset: tx_done_tick pulsed in IDLE gives no state change. Reset is asserted during WAIT. Required: grant=0, tx_start=0, busy=0 asynchronously. After release, client 0 wins over client 1 when both request.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: default byte width,
// arbiter FSM state encoding and a constant-evaluable clog2.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Never returns less than 1 so that a 1-bit pointer still exists for two clients.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 16; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request scanning upward
// from i_rr_ptr+1 (mod NUM_REQ); returns it as one-hot and as an index.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0]   o_sel
);

    logic w_found;
    int   w_idx;

    // Rotating priority scan; the client at i_rr_ptr itself is checked last.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        o_gnt   = '0;
        o_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_sel        = SEL_W'(w_idx);
                w_found      = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte clients with round-robin
// grants and bounded back-to-back bursts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          tx_start,
    output logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_done_tick,
    output logic                          busy
);

    localparam int SEL_W = clog2(NUM_REQ);

    state_t                r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      r_rr_ptr;
    logic [DATA_BITS-1:0]  r_tx_data;
    logic [3:0]            r_burst_cnt;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [SEL_W-1:0]      w_sel;
    logic [DATA_BITS-1:0]  w_new_byte;
    logic [DATA_BITS-1:0]  w_own_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_arbiter (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_gnt),
        .o_sel    (w_sel)
    );

    assign w_new_byte = req_data[w_sel*DATA_BITS +: DATA_BITS];
    assign w_own_byte = req_data[r_sel*DATA_BITS +: DATA_BITS];

    // Grant / launch / wait sequencer; the owner's pointer is recorded on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_sel       <= '0;
            r_rr_ptr    <= SEL_W'(NUM_REQ - 1);
            r_tx_data   <= '0;
            r_burst_cnt <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req != '0) begin
                        r_grant     <= w_gnt;
                        r_sel       <= w_sel;
                        r_tx_data   <= w_new_byte;
                        r_burst_cnt <= 4'd0;
                        r_state     <= START;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                START: begin
                    r_burst_cnt <= r_burst_cnt + 4'd1;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (req[r_sel] && (r_burst_cnt < 4'(MAX_BURST))) begin
                            r_tx_data <= w_own_byte;
                            r_state   <= START;
                        end else begin
                            r_rr_ptr <= r_sel;
                            r_grant  <= '0;
                            r_state  <= IDLE;
                        end
                    end else begin
                        r_state <= WAIT;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Launch and ack are decoded from registered state so they last exactly the START cycle.
    assign tx_start = (r_state == START);
    assign req_ack  = tx_start ? r_grant : '0;
    assign grant    = r_grant;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (MAX_BURST=4 and 1) share
// stimulus; each scenario task observes the instance it targets.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0000_0000;
    logic        tx_done_tick = 1'b0;

    logic [3:0]  ack0, grant0, ack1, grant1;
    logic        start0, busy0, start1, busy1;
    logic [7:0]  data0, data1;

    logic        sel_dut = 1'b0;
    logic [3:0]  obs_ack, obs_grant;
    logic        obs_start, obs_busy;
    logic [7:0]  obs_data;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_ack(ack0), .grant(grant0), .tx_start(start0), .tx_data(data0),
        .tx_done_tick(tx_done_tick), .busy(busy0)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_ack(ack1), .grant(grant1), .tx_start(start1), .tx_data(data1),
        .tx_done_tick(tx_done_tick), .busy(busy1)
    );

    assign obs_ack   = sel_dut ? ack1   : ack0;
    assign obs_grant = sel_dut ? grant1 : grant0;
    assign obs_start = sel_dut ? start1 : start0;
    assign obs_busy  = sel_dut ? busy1  : busy0;
    assign obs_data  = sel_dut ? data1  : data0;

    task automatic do_reset();
        req = 4'b0000;
        tx_done_tick = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_tick();
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant0, ack0, start0, data0, busy0} !== 18'd0) begin
            $display("FAIL reset_b4: got grant=%b ack=%b start=%b data=%h busy=%b, expected all zero", grant0, ack0, start0, data0, busy0);
        end else passes++;
        checks++;
        if ({grant1, ack1, start1, data1, busy1} !== 18'd0) begin
            $display("FAIL reset_b1: got grant=%b ack=%b start=%b data=%h busy=%b, expected all zero", grant1, ack1, start1, data1, busy1);
        end else passes++;
    endtask

    task automatic test_single();
        sel_dut = 1'b0;
        do_reset();
        req = 4'b0001;
        req_data = 32'h0000_00A5;
        @(negedge clk);
        checks++;
        if ({obs_grant, obs_start, obs_data, obs_ack, obs_busy} !== {4'b0001, 1'b1, 8'hA5, 4'b0001, 1'b1}) begin
            $display("FAIL single_launch: got grant=%b start=%b data=%h ack=%b busy=%b, expected 0001 1 a5 0001 1", obs_grant, obs_start, obs_data, obs_ack, obs_busy);
        end else passes++;
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if ({obs_grant, obs_start, obs_ack, obs_busy} !== {4'b0001, 1'b0, 4'b0000, 1'b1}) begin
            $display("FAIL single_wait: got grant=%b start=%b ack=%b busy=%b, expected 0001 0 0000 1", obs_grant, obs_start, obs_ack, obs_busy);
        end else passes++;
        pulse_tick();
        checks++;
        if ({obs_grant, obs_busy, obs_data} !== {4'b0000, 1'b0, 8'hA5}) begin
            $display("FAIL single_release: got grant=%b busy=%b data=%h, expected 0000 0 a5", obs_grant, obs_busy, obs_data);
        end else passes++;
    endtask

    task automatic test_contention();
        logic [7:0] exp_b [4];
        logic [3:0] exp_a [4];
        int n;
        exp_b = '{8'h22, 8'h33, 8'h22, 8'h33};
        exp_a = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        sel_dut = 1'b1;
        do_reset();
        req = 4'b0110;
        req_data = 32'h4433_2211;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!obs_start && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!obs_start) begin
                $display("FAIL contention_timeout %0d: got no tx_start, expected launch of %h", i, exp_b[i]);
            end else begin
                passes++;
                checks++;
                if ({obs_data, obs_ack} !== {exp_b[i], exp_a[i]}) begin
                    $display("FAIL contention_byte %0d: got data=%h ack=%b, expected %h %b", i, obs_data, obs_ack, exp_b[i], exp_a[i]);
                end else passes++;
            end
            repeat (10) @(negedge clk);
            pulse_tick();
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [7];
        int         exp_gap [7];
        int         n;
        int         c0;
        exp_b   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h77, 8'h05, 8'h06};
        exp_gap = '{1, 0, 0, 0, 1, 1, 0};
        sel_dut = 1'b0;
        do_reset();
        c0 = 0;
        req_data = 32'h0077_0001;
        req = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            n = 0;
            while (!obs_start && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!obs_start) begin
                $display("FAIL burst_timeout %0d: got no tx_start, expected launch of %h", i, exp_b[i]);
            end else begin
                passes++;
                checks++;
                if (obs_data !== exp_b[i] || n != exp_gap[i]) begin
                    $display("FAIL burst_byte %0d: got data=%h gap=%0d, expected %h gap=%0d", i, obs_data, n, exp_b[i], exp_gap[i]);
                end else passes++;
            end
            if (obs_ack[0]) begin
                c0++;
                if (c0 < 6) req_data[7:0] = 8'(c0 + 1);
                else req[0] = 1'b0;
            end
            if (obs_ack[2]) req[2] = 1'b0;
            repeat (5) @(negedge clk);
            pulse_tick();
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({obs_busy, obs_grant} !== 5'b0_0000) begin
            $display("FAIL burst_end: got busy=%b grant=%b, expected 0 0000", obs_busy, obs_grant);
        end else passes++;
    endtask

    task automatic test_drop_in_wait();
        int starts;
        int acks;
        sel_dut = 1'b0;
        do_reset();
        req_data = 32'h5A00_0000;
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if ({obs_start, obs_data, obs_ack} !== {1'b1, 8'h5A, 4'b1000}) begin
            $display("FAIL drop_launch: got start=%b data=%h ack=%b, expected 1 5a 1000", obs_start, obs_data, obs_ack);
        end else passes++;
        req = 4'b0000;
        starts = 0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (obs_start) starts++;
            if (obs_ack != 4'b0000) acks++;
        end
        pulse_tick();
        repeat (8) begin
            if (obs_start) starts++;
            if (obs_ack != 4'b0000) acks++;
            @(negedge clk);
        end
        checks++;
        if (starts != 0 || acks != 0 || obs_busy !== 1'b0 || obs_grant !== 4'b0000) begin
            $display("FAIL drop_after: got extra starts=%0d acks=%0d busy=%b grant=%b, expected 0 0 0 0000", starts, acks, obs_busy, obs_grant);
        end else passes++;
    endtask

    task automatic test_stray_and_reset();
        sel_dut = 1'b0;
        do_reset();
        pulse_tick();
        checks++;
        if ({obs_busy, obs_grant, obs_start} !== 6'd0) begin
            $display("FAIL stray_tick: got busy=%b grant=%b start=%b, expected 0 0000 0", obs_busy, obs_grant, obs_start);
        end else passes++;
        req_data = 32'h0000_BB00;
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if ({obs_start, obs_grant, obs_data} !== {1'b1, 4'b0010, 8'hBB}) begin
            $display("FAIL stray_grant: got start=%b grant=%b data=%h, expected 1 0010 bb", obs_start, obs_grant, obs_data);
        end else passes++;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({obs_grant, obs_start, obs_busy, obs_ack} !== 10'd0) begin
            $display("FAIL async_reset: got grant=%b start=%b busy=%b ack=%b, expected all zero", obs_grant, obs_start, obs_busy, obs_ack);
        end else passes++;
        @(negedge clk);
        reset = 1'b0;
        req_data = 32'h0000_C33C;
        req = 4'b0011;
        @(negedge clk);
        checks++;
        if ({obs_grant, obs_data, obs_start} !== {4'b0001, 8'h3C, 1'b1}) begin
            $display("FAIL post_reset_prio: got grant=%b data=%h start=%b, expected 0001 3c 1", obs_grant, obs_data, obs_start);
        end else passes++;
        req = 4'b0000;
        @(negedge clk);
        pulse_tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_drop_in_wait();
        test_stray_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
